// File: rtl/newton_step_mul.sv
// Final Newton-Raphson step: 3-stage FP32 multiply, y1 = num_a * init.
// Define NEWTON_MUL_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module newton_step_mul #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] num_a,
  input  logic [31:0] init,
  output logic        out_valid,
  output logic [31:0] result
);

  logic [7:0] ea, eb;
  logic       s1_zero_d, s1_inf_d, s1_sign_d;
  logic signed [9:0] s1_e_d;

  logic              v1_q, sign1_q, zero1_q, inf1_q;
  logic signed [9:0] e1_q;
  logic [23:0]       ma1_q, mb1_q;

  logic              v2_q, sign2_q, zero2_q, inf2_q;
  logic signed [9:0] e2_q;
  logic [47:0]       p2_q;

  logic              out_valid_q;
  logic [31:0]       result_q, result_d;
  logic signed [9:0] e3;
  logic [22:0]       frac3;

  assign ea        = num_a[30:23];
  assign eb        = init[30:23];
  assign s1_sign_d = num_a[31] ^ init[31];
  assign s1_zero_d = (ea == 8'h00) || (eb == 8'h00);
  assign s1_inf_d  = (ea == 8'hFF) || (eb == 8'hFF);
  assign s1_e_d    = $signed({2'b00, ea}) + $signed({2'b00, eb})
                   - $signed(10'(BIAS));

  // Valid bits and the visible output are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
    end else begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        result_q <= result_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    sign1_q <= s1_sign_d;
    zero1_q <= s1_zero_d;
    inf1_q  <= s1_inf_d;
    e1_q    <= s1_e_d;
    ma1_q   <= {1'b1, num_a[22:0]};
    mb1_q   <= {1'b1, init[22:0]};
    sign2_q <= sign1_q;
    zero2_q <= zero1_q;
    inf2_q  <= inf1_q;
    e2_q    <= e1_q;
    p2_q    <= 48'(ma1_q) * 48'(mb1_q);
  end

`ifdef NEWTON_MUL_ROUND_NEAREST_EN
  logic        grd, sticky;
  logic [22:0] frac_n;
  logic [23:0] frac_r;

  always_comb begin
    e3     = e2_q;
    frac_n = p2_q[45:23];
    grd    = p2_q[22];
    sticky = |p2_q[21:0];
    if (p2_q[47]) begin
      e3     = e2_q + 10'sd1;
      frac_n = p2_q[46:24];
      grd    = p2_q[23];
      sticky = |p2_q[22:0];
    end
    frac_r = {1'b0, frac_n} + 24'(grd & (sticky | frac_n[0]));
    frac3  = frac_r[22:0];
    if (frac_r[23]) begin
      frac3 = 23'h0;
      e3    = e3 + 10'sd1;
    end
  end
`else
  logic unused_tail;

  assign unused_tail = |p2_q[22:0];

  always_comb begin
    e3    = e2_q;
    frac3 = p2_q[45:23];
    if (p2_q[47]) begin
      e3    = e2_q + 10'sd1;
      frac3 = p2_q[46:24];
    end
  end
`endif

  always_comb begin
    result_d = {sign2_q, e3[7:0], frac3};
    if (inf2_q && zero2_q) begin
      result_d = 32'h7FC00000;
    end else if (inf2_q) begin
      result_d = {sign2_q, 8'hFF, 23'h0};
    end else if (zero2_q) begin
      result_d = {sign2_q, 8'h00, 23'h0};
    end else if (e3 >= 10'sd255) begin
      result_d = {sign2_q, 8'hFF, 23'h0};
    end else if (e3 <= 10'sd0) begin
      result_d = {sign2_q, 8'h00, 23'h0};
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_newton_step_mul.sv
// Scoreboard bench for newton_step_mul.
// Expected products are hand-derived FP32 constants, checked with cycle stamps.
module tb_newton_step_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] num_a, init;
  logic        out_valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] exp;
    int          due;
  } sb_t;

  sb_t q[$];
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;

  newton_step_mul dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .num_a    (num_a),
    .init     (init),
    .out_valid(out_valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("result", result, e.exp);
        check_eq("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check_eq("missing_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  // One clock: inputs set before the call are sampled at the next posedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    sb_t e;
    in_valid = 1'b1;
    num_a    = a;
    init     = b;
    e.exp    = exp;
    e.due    = cyc + 3;
    q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic bubble(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    num_a    = 32'h0;
    init     = 32'h0;
    @(negedge clk);
    step();
    step();
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_result", result, 32'h0);
    rst = 1'b0;

    // 1.5 * 2.0
    issue(32'h3FC00000, 32'h40000000, 32'h40400000);
    bubble(4);
    check_eq("hold_valid", 32'(out_valid), 32'd0);
    check_eq("hold_result", result, 32'h40400000);

    issue(32'h3F800000, 32'h3F800000, 32'h3F800000);
    bubble(1);
    issue(32'h3FC00000, 32'hC0000000, 32'hC0400000);
    bubble(1);
    issue(32'h3F000000, 32'h3F000000, 32'h3E800000);
    bubble(1);
    bubble(3);

    // Back-to-back stream
    issue(32'h40400000, 32'h40800000, 32'h41400000);
    issue(32'h00000000, 32'hC0000000, 32'h80000000);
    issue(32'h00000001, 32'h3F800000, 32'h00000000);
    issue(32'h7F000000, 32'h40000000, 32'h7F800000);
    issue(32'h00800000, 32'h3F000000, 32'h00000000);
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000);
    issue(32'hFF800000, 32'h3F800000, 32'hFF800000);
`ifdef NEWTON_MUL_ROUND_NEAREST_EN
    issue(32'h3FC00001, 32'h3FC00001, 32'h40100002);
`else
    issue(32'h3FC00001, 32'h3FC00001, 32'h40100001);
`endif
    bubble(5);

    // Reset while two pairs are in flight
    issue(32'h40000000, 32'h40000000, 32'h40800000);
    issue(32'h40400000, 32'h40400000, 32'h41100000);
    q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_flush_valid", 32'(out_valid), 32'd0);
      check_eq("rst_flush_result", result, 32'h0);
      if (i < 3) step();
    end
    issue(32'h3FC00000, 32'h40000000, 32'h40400000);
    bubble(5);

    check_eq("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
